avalon_led_sequencer: RTL and testbench

//  Avalon-MM controller that plays a programmable LED pattern sequence into the LED register slave.
//  CPU loads a pattern table, step period and length via the slave port, then sets RUN.

---
 rtl/avalon_led_seq_pkg.sv | 37 +++
 rtl/led_seq_tick_gen.sv | 29 ++
 rtl/avalon_led_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_avalon_led_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_led_seq_pkg.sv
// Shared definitions for the Avalon LED sequencer: register map, CTRL/STATUS
// bit positions, FSM state encoding and the LENGTH clamp helper.
package avalon_led_seq_pkg;

  localparam logic [4:0] REG_CTRL       = 5'd0;
  localparam logic [4:0] REG_STATUS     = 5'd1;
  localparam logic [4:0] REG_PERIOD     = 5'd2;
  localparam logic [4:0] REG_LENGTH     = 5'd3;
  localparam logic [4:0] REG_TABLE_BASE = 5'd16;

  localparam int CTRL_RUN       = 0;
  localparam int CTRL_LOOP      = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_DONE    = 1;
  localparam int STATUS_IDX_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } seq_state_e;

  // A zero length still plays one step; anything beyond the table plays the whole table.
  function automatic logic [31:0] clamp_length(input logic [31:0] value, input logic [31:0] depth);
    logic [31:0] result;
    if (value == 32'd0) begin
      result = 32'd1;
    end else if (value > depth) begin
      result = depth;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/led_seq_tick_gen.sv
// Step-period down-counter. 'zero' is high when the count is 0 or will reach 0
// on this enabled cycle, so a load of N-1 yields writes spaced N cycles apart.
module led_seq_tick_gen #(
  parameter int PER_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [PER_W-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [PER_W-1:0] cnt_r;

  // Counter: load has priority, otherwise count down to zero and hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {PER_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_value;
    end else if (enable && (cnt_r != {PER_W{1'b0}})) begin
      cnt_r <= cnt_r - PER_W'(1'b1);
    end
  end

  assign zero = (cnt_r == {PER_W{1'b0}}) | (enable & (cnt_r == PER_W'(1'b1)));

endmodule

// File: rtl/avalon_led_sequencer.sv
// Avalon-MM LED pattern sequencer: CPU-programmed table played as timed master
// writes. Optional LED_SEQ_IRQ_EN adds the IRQ_EN control bit and a done interrupt.
module avalon_led_sequencer
  import avalon_led_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LED_W = 8,
  parameter int PER_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  s_address,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  output logic [15:0] m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        irq
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LEN_W = IDX_W + 1;

  seq_state_e       state_r, state_next_s;
  logic             run_r, loop_r, done_r, restart_pend_r, irq_en_s;
  logic [PER_W-1:0] period_r, tick_value_s;
  logic [LEN_W-1:0] length_r;
  logic [LED_W-1:0] table_r [DEPTH];
  logic [IDX_W-1:0] idx_r, idx_next_s, tbl_idx_s;
  logic [LED_W-1:0] pattern_r;
  logic [31:0]      readdata_r, rd_mux_s, status_s;
  logic             m_write_r, m_write_next_s, load_pattern_s;
  logic             wr_ctrl_s, wr_status_s, wr_period_s, wr_length_s, tbl_hit_s;
  logic             accept_s, last_s, autoclr_s, start_s, done_set_s;
  logic             tick_load_s, tick_en_s, tick_zero_s;

  assign wr_ctrl_s   = s_write & (s_address == REG_CTRL);
  assign wr_status_s = s_write & (s_address == REG_STATUS);
  assign wr_period_s = s_write & (s_address == REG_PERIOD);
  assign wr_length_s = s_write & (s_address == REG_LENGTH);
  assign tbl_hit_s   = s_address[4] & ({1'b0, s_address[3:0]} < 5'(DEPTH));
  assign tbl_idx_s   = s_address[IDX_W-1:0];

  assign accept_s  = (state_r == ST_WRITE) & ~m_waitrequest;
  assign last_s    = ({1'b0, idx_r} == (length_r - LEN_W'(1'b1)));
  assign autoclr_s = accept_s & run_r & last_s & ~loop_r;
  // A RUN=1 write landing on the auto-clear cycle counts as a fresh start.
  assign start_s   = wr_ctrl_s & s_writedata[CTRL_RUN] & (~run_r | autoclr_s);

  assign tick_value_s = (period_r == {PER_W{1'b0}}) ? {PER_W{1'b0}} : (period_r - PER_W'(1'b1));
  assign tick_en_s    = (state_r == ST_WAIT);

  led_seq_tick_gen #(.PER_W(PER_W)) u_tick_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (tick_load_s),
    .load_value (tick_value_s),
    .enable     (tick_en_s),
    .zero       (tick_zero_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
    end
  end

  // FSM next-state and step index.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    tick_load_s  = 1'b0;
    done_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_next_s = ST_WRITE;
          idx_next_s   = {IDX_W{1'b0}};
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (!accept_s) begin
          state_next_s = ST_WRITE;
        end else if (start_s || restart_pend_r) begin
          state_next_s = ST_WRITE;
          idx_next_s   = {IDX_W{1'b0}};
        end else if (!run_r) begin
          state_next_s = ST_IDLE;
        end else if (last_s && !loop_r) begin
          state_next_s = ST_IDLE;
          done_set_s   = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
          idx_next_s   = last_s ? {IDX_W{1'b0}} : (idx_r + IDX_W'(1'b1));
          tick_load_s  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (start_s) begin
          state_next_s = ST_WRITE;
          idx_next_s   = {IDX_W{1'b0}};
        end else if (!run_r) begin
          state_next_s = ST_IDLE;
        end else if (tick_zero_s) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        idx_next_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // FSM output decode: the pattern is fetched only when a new transfer begins.
  always_comb begin
    m_write_next_s = (state_next_s == ST_WRITE);
    load_pattern_s = m_write_next_s & ((state_r != ST_WRITE) | accept_s);
  end

  // Master port registers; writedata stays frozen for the whole transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_write_r <= 1'b0;
      pattern_r <= {LED_W{1'b0}};
    end else begin
      m_write_r <= m_write_next_s;
      if (load_pattern_s) begin
        pattern_r <= table_r[idx_next_s];
      end
    end
  end

  // Control, configuration and pattern table registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_r          <= 1'b0;
      loop_r         <= 1'b0;
      done_r         <= 1'b0;
      restart_pend_r <= 1'b0;
      period_r       <= PER_W'(1'b1);
      length_r       <= LEN_W'(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= {LED_W{1'b0}};
      end
    end else begin
      if (wr_ctrl_s) begin
        run_r  <= s_writedata[CTRL_RUN];
        loop_r <= s_writedata[CTRL_LOOP];
      end else if (autoclr_s) begin
        run_r <= 1'b0;
      end
      if (start_s) begin
        done_r <= 1'b0;
      end else if (done_set_s) begin
        done_r <= 1'b1;
      end else if (wr_status_s && s_writedata[STATUS_DONE]) begin
        done_r <= 1'b0;
      end
      if (accept_s) begin
        restart_pend_r <= 1'b0;
      end else if (start_s && (state_r == ST_WRITE)) begin
        restart_pend_r <= 1'b1;
      end
      if (wr_period_s) begin
        period_r <= s_writedata[PER_W-1:0];
      end
      if (wr_length_s) begin
        length_r <= LEN_W'(clamp_length(s_writedata, 32'(DEPTH)));
      end
      if (s_write && tbl_hit_s) begin
        table_r[tbl_idx_s] <= s_writedata[LED_W-1:0];
      end
    end
  end

`ifdef LED_SEQ_IRQ_EN
  logic irq_en_r, irq_r;

  // Interrupt enable bit and registered done interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        irq_en_r <= s_writedata[CTRL_IRQ_EN];
      end
      irq_r <= done_r & irq_en_r;
    end
  end

  assign irq_en_s = irq_en_r;
  assign irq      = irq_r;
`else
  assign irq_en_s = 1'b0;
  assign irq      = 1'b0;
`endif

  // Slave read multiplexer.
  always_comb begin
    status_s = 32'd0;
    status_s[STATUS_BUSY] = (state_r != ST_IDLE);
    status_s[STATUS_DONE] = done_r;
    status_s[STATUS_IDX_LSB +: IDX_W] = idx_r;
    rd_mux_s = 32'd0;
    case (s_address)
      REG_CTRL:   rd_mux_s = {29'd0, irq_en_s, loop_r, run_r};
      REG_STATUS: rd_mux_s = status_s;
      REG_PERIOD: rd_mux_s = 32'(period_r);
      REG_LENGTH: rd_mux_s = 32'(length_r);
      default: begin
        if (tbl_hit_s) begin
          rd_mux_s = 32'(table_r[tbl_idx_s]);
        end else begin
          rd_mux_s = 32'd0;
        end
      end
    endcase
  end

  // Read data register, valid the cycle after s_read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 32'd0;
    end else begin
      readdata_r <= s_read ? rd_mux_s : 32'd0;
    end
  end

  assign s_readdata  = readdata_r;
  assign m_address   = 16'd0;
  assign m_write     = m_write_r;
  assign m_writedata = 32'(pattern_r);

endmodule

// File: tb/tb_avalon_led_sequencer.sv
// Scoreboard bench for avalon_led_sequencer: expected patterns are queued at
// each run start and matched against accepted master writes.
module tb_avalon_led_sequencer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  s_address = 5'd0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = 32'd0;
  logic        s_read = 1'b0;
  logic [31:0] s_readdata;
  logic [15:0] m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;
  logic        irq;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_val;
  int cyc = 0;
  int acc_cnt = 0;
  int last_acc = 0;
  int exp_gap = 0;
  bit gap_armed = 1'b0;
  int base;

  avalon_led_sequencer #(.DEPTH(DEPTH), .LED_W(8), .PER_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_address     (s_address),
    .s_write       (s_write),
    .s_writedata   (s_writedata),
    .s_read        (s_read),
    .s_readdata    (s_readdata),
    .m_address     (m_address),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accept monitor: sampled mid-low-phase, the transfer completes at the next rising edge.
  always @(negedge clk) begin
    #2;
    if (reset_n && m_write && !m_waitrequest) begin
      acc_cnt++;
      check_eq("m_address", 32'(m_address), 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_val = exp_q.pop_front();
        check_eq("pattern", m_writedata, exp_val);
      end
      if (exp_gap != 0 && gap_armed) begin
        check_eq("gap", 32'(cyc - last_acc), 32'(exp_gap));
      end
      last_acc  = cyc;
      gap_armed = 1'b1;
    end
  end

  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    s_address   = addr;
    s_writedata = data;
    s_write     = 1'b1;
    @(negedge clk);
    s_write = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    @(negedge clk);
    s_address = addr;
    s_read    = 1'b1;
    @(negedge clk);
    s_read = 1'b0;
    check_eq(tag, s_readdata, exp);
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (acc_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_acc", 32'(acc_cnt), 32'(target));
  endtask

  task automatic wait_mwrite(input string tag, input int budget);
    int n = 0;
    while (!m_write && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(m_write), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    reset_n = 1'b1;
    idle(1);

    // Reset state
    check_eq("rst_m_write", 32'(m_write), 32'd0);
    check_eq("rst_m_writedata", m_writedata, 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    read_check("rst_ctrl", 5'd0, 32'd0);
    read_check("rst_status", 5'd1, 32'd0);
    read_check("rst_period", 5'd2, 32'd1);
    read_check("rst_length", 5'd3, 32'd8);
    read_check("rst_table0", 5'd16, 32'd0);

    // Basic three-step sequence, PERIOD 4
    bus_write(5'd16, 32'h01);
    bus_write(5'd17, 32'h02);
    bus_write(5'd18, 32'h04);
    bus_write(5'd2, 32'd4);
    bus_write(5'd3, 32'd3);
    read_check("table1_rb", 5'd17, 32'h02);
    exp_gap = 4; gap_armed = 1'b0;
    exp_q.push_back(32'h01); exp_q.push_back(32'h02); exp_q.push_back(32'h04);
    base = acc_cnt;
    bus_write(5'd0, 32'h1);
    check_eq("first_immediate", 32'(m_write), 32'd1);
    wait_acc(base + 3, 100);
    idle(8);
    check_eq("basic_count", 32'(acc_cnt), 32'(base + 3));
    check_eq("basic_sb_empty", 32'(exp_q.size()), 32'd0);
    read_check("basic_status", 5'd1, 32'h202);
    read_check("basic_ctrl", 5'd0, 32'h0);

    // Looping, stopped by clearing RUN while waiting
    bus_write(5'd2, 32'd6);
    exp_gap = 6; gap_armed = 1'b0;
    exp_q.push_back(32'h01); exp_q.push_back(32'h02);
    exp_q.push_back(32'h04); exp_q.push_back(32'h01);
    base = acc_cnt;
    bus_write(5'd0, 32'h3);
    wait_acc(base + 4, 200);
    bus_write(5'd0, 32'h2);
    idle(20);
    check_eq("loop_count", 32'(acc_cnt), 32'(base + 4));
    check_eq("loop_sb_empty", 32'(exp_q.size()), 32'd0);
    read_check("loop_status", 5'd1, 32'h100);
    read_check("loop_ctrl", 5'd0, 32'h2);

    // Wait-request stall on the second write
    bus_write(5'd0, 32'h0);
    bus_write(5'd2, 32'd4);
    exp_gap = 0;
    exp_q.push_back(32'h01); exp_q.push_back(32'h02); exp_q.push_back(32'h04);
    base = acc_cnt;
    bus_write(5'd0, 32'h1);
    wait_acc(base + 1, 50);
    m_waitrequest = 1'b1;
    wait_mwrite("stall_seen", 50);
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_m_write", 32'(m_write), 32'd1);
      check_eq("stall_data", m_writedata, 32'h02);
      @(negedge clk);
    end
    check_eq("stall_data_last", m_writedata, 32'h02);
    check_eq("stall_no_accept", 32'(acc_cnt), 32'(base + 1));
    m_waitrequest = 1'b0;
    wait_acc(base + 3, 100);
    idle(8);
    check_eq("stall_count", 32'(acc_cnt), 32'(base + 3));
    check_eq("stall_sb_empty", 32'(exp_q.size()), 32'd0);
    read_check("stall_status", 5'd1, 32'h202);

    // PERIOD 0 and LENGTH 0 give one write per start
    bus_write(5'd2, 32'd0);
    bus_write(5'd3, 32'd0);
    read_check("period0_rb", 5'd2, 32'd0);
    read_check("length0_rb", 5'd3, 32'd1);
    base = acc_cnt;
    exp_q.push_back(32'h01);
    bus_write(5'd0, 32'h1);
    idle(20);
    check_eq("single_count1", 32'(acc_cnt), 32'(base + 1));
    read_check("single_status", 5'd1, 32'h002);
    exp_q.push_back(32'h01);
    bus_write(5'd0, 32'h1);
    idle(20);
    check_eq("single_count2", 32'(acc_cnt), 32'(base + 2));

    // LENGTH above DEPTH clamps to DEPTH
    bus_write(5'd3, 32'd20);
    read_check("length20_rb", 5'd3, 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      bus_write(5'(16 + i), 32'(8'h10 + i));
    end
    bus_write(5'd2, 32'd1);
    exp_gap = 2; gap_armed = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(32'(8'h10 + i));
    end
    base = acc_cnt;
`ifdef LED_SEQ_IRQ_EN
    bus_write(5'd0, 32'h5);
`else
    bus_write(5'd0, 32'h1);
`endif
    wait_acc(base + DEPTH, 200);
    idle(10);
    check_eq("full_count", 32'(acc_cnt), 32'(base + DEPTH));
    check_eq("full_sb_empty", 32'(exp_q.size()), 32'd0);
    read_check("full_status", 5'd1, 32'h702);
`ifdef LED_SEQ_IRQ_EN
    check_eq("irq_set", 32'(irq), 32'd1);
    read_check("irq_ctrl", 5'd0, 32'h4);
`else
    check_eq("irq_tied", 32'(irq), 32'd0);
    bus_write(5'd0, 32'h4);
    read_check("irq_en_absent", 5'd0, 32'h0);
`endif
    bus_write(5'd1, 32'h2);
    idle(3);
    check_eq("irq_clear", 32'(irq), 32'd0);
    read_check("w1c_status", 5'd1, 32'h700);

    // Unmapped addresses
    bus_write(5'd5, 32'hFFFF_FFFF);
    bus_write(5'd24, 32'hFFFF_FFFF);
    read_check("unmapped5", 5'd5, 32'd0);
    read_check("unmapped24", 5'd24, 32'd0);

    // Reset in the middle of a stalled transfer
    exp_gap = 0;
    m_waitrequest = 1'b1;
    bus_write(5'd0, 32'h1);
    wait_mwrite("rst_mid_seen", 20);
    check_eq("rst_mid_data", m_writedata, 32'h10);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_m_write", 32'(m_write), 32'd0);
    check_eq("rst_mid_m_writedata", m_writedata, 32'd0);
    @(negedge clk);
    m_waitrequest = 1'b0;
    reset_n = 1'b1;
    idle(1);
    read_check("rst_mid_status", 5'd1, 32'd0);
    read_check("rst_mid_ctrl", 5'd0, 32'd0);
    read_check("rst_mid_length", 5'd3, 32'd8);
    read_check("rst_mid_period", 5'd2, 32'd1);
    idle(5);
    check_eq("rst_mid_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
